// File: rtl/sm_product_accumulator.sv
// Frame accumulator for sign-magnitude products with saturating sum.
// Optional nonzero-beat counter enabled by SM_ACC_STATS_EN.
module sm_product_accumulator #(
    parameter int PROD_W = 7,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [7:0]        out_cnt
`ifdef SM_ACC_STATS_EN
    ,
    output logic [7:0]        out_nz_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic signed [ACC_W:0] W_MAX =
        $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] W_MIN = -W_MAX;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    logic [7:0]              r_cnt;
    logic [ACC_W-1:0]        r_osum;
    logic                    r_oovf;
    logic [7:0]              r_ocnt;

    logic [PROD_W-2:0]       w_mag;
    logic signed [ACC_W:0]   w_addend;
    logic signed [ACC_W:0]   w_acc_ext;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_ovf_nxt;
    logic [7:0]              w_cnt_nxt;
    logic                    w_take;
    logic                    w_pop;
    logic                    w_last;
    logic                    w_neg;
    logic [ACC_W-2:0]        w_abs;

    assign w_mag     = in_prod[PROD_W-2:0];
    assign w_acc_ext = $signed({r_acc[ACC_W-1], r_acc});
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_take    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_last    = in_last || (r_cnt == 8'(COUNT - 1));

    // Negating a zero magnitude yields +0, so -0 needs no special case.
    always_comb begin
        w_addend = $signed({{(ACC_W+2-PROD_W){1'b0}}, w_mag});
        if (in_prod[PROD_W-1])
            w_addend = -w_addend;
    end

    assign w_sum = w_acc_ext + w_addend;

    // Once saturated the accumulator is frozen for the rest of the frame.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (!r_ovf) begin
            if (w_sum > W_MAX) begin
                w_ovf_nxt = 1'b1;
                w_acc_nxt = W_MAX[ACC_W-1:0];
            end else if (w_sum < W_MIN) begin
                w_ovf_nxt = 1'b1;
                w_acc_nxt = W_MIN[ACC_W-1:0];
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end
        end
    end

    assign w_neg = w_acc_nxt[ACC_W-1];
    assign w_abs = w_neg ? (~w_acc_nxt[ACC_W-2:0] + 1'b1)
                         : w_acc_nxt[ACC_W-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE, S_ACC: begin
                if (w_take)
                    w_state_nxt = w_last ? S_DONE : S_ACC;
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
            r_osum <= '0;
            r_oovf <= 1'b0;
            r_ocnt <= '0;
        end else if (w_take) begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
                r_osum <= {w_neg, w_abs};
                r_oovf <= w_ovf_nxt;
                r_ocnt <= w_cnt_nxt;
            end
        end else if (w_pop) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end
    end

    assign out_sum = r_osum;
    assign out_ovf = r_oovf;
    assign out_cnt = r_ocnt;

`ifdef SM_ACC_STATS_EN
    logic [7:0] r_nz;
    logic [7:0] r_onz;
    logic [7:0] w_nz_nxt;

    assign w_nz_nxt = r_nz + {7'd0, |w_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz  <= '0;
            r_onz <= '0;
        end else if (w_take) begin
            r_nz <= w_nz_nxt;
            if (w_last)
                r_onz <= w_nz_nxt;
        end else if (w_pop) begin
            r_nz <= '0;
        end
    end

    assign out_nz_cnt = r_onz;
`endif

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed test of sm_product_accumulator at ACC_W=12 and ACC_W=8.
module tb_sm_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_prod;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_cnt;

    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_sum8;
    logic        out_ovf8;
    logic [7:0]  out_cnt8;

`ifdef SM_ACC_STATS_EN
    logic [7:0]  out_nz_cnt;
    logic [7:0]  out_nz_cnt8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sm_product_accumulator #(
        .PROD_W(7), .ACC_W(12), .COUNT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf),
        .out_cnt(out_cnt)
`ifdef SM_ACC_STATS_EN
        , .out_nz_cnt(out_nz_cnt)
`endif
    );

    sm_product_accumulator #(
        .PROD_W(7), .ACC_W(8), .COUNT(8)
    ) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_ovf(out_ovf8),
        .out_cnt(out_cnt8)
`ifdef SM_ACC_STATS_EN
        , .out_nz_cnt(out_nz_cnt8)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [6:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_ovf",   32'(out_ovf),   32'd0);
        chk("rst_cnt",   32'(out_cnt),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full 8-beat frame ends on count
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            beat(7'h31, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum",   32'(out_sum),   32'h188);
        chk("t1_ovf",   32'(out_ovf),   32'd0);
        chk("t1_cnt",   32'(out_cnt),   32'd8);
`ifdef SM_ACC_STATS_EN
        chk("t1_nz",    32'(out_nz_cnt), 32'd8);
`endif
        @(posedge clk);
        #1;
        chk("t1_idle_v", 32'(out_valid), 32'd0);
        chk("t1_idle_r", 32'(in_ready),  32'd1);

        // 2: mixed signs ended by in_last
        beat(7'h31, 1'b0);
        beat(7'h71, 1'b0);
        beat(7'h43, 1'b0);
        beat(7'h07, 1'b1);
        chk("t2_sum", 32'(out_sum), 32'h004);
        chk("t2_cnt", 32'(out_cnt), 32'd4);
        chk("t2_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1;

        // 3: single negative-zero beat
        beat(7'h40, 1'b1);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_sum",   32'(out_sum),   32'h000);
        chk("t3_cnt",   32'(out_cnt),   32'd1);
`ifdef SM_ACC_STATS_EN
        chk("t3_nz",    32'(out_nz_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        // 4: saturation on the 8-bit instance
        beat(7'h31, 1'b0);
        beat(7'h31, 1'b0);
        beat(7'h31, 1'b0);
        beat(7'h71, 1'b1);
        chk("t4_ovf8",  32'(out_ovf8),  32'd1);
        chk("t4_sum8",  32'(out_sum8),  32'h7F);
        chk("t4_cnt8",  32'(out_cnt8),  32'd4);
        chk("t4_sum12", 32'(out_sum),   32'h062);
        chk("t4_ovf12", 32'(out_ovf),   32'd0);
        @(posedge clk);
        #1;

        // 5: backpressure while DONE
        out_ready = 1'b0;
        beat(7'h05, 1'b0);
        beat(7'h4A, 1'b1);
        in_valid = 1'b1;
        in_prod  = 7'h3F;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_ready", 32'(in_ready),  32'd0);
            chk("t5_valid", 32'(out_valid), 32'd1);
            chk("t5_sum",   32'(out_sum),   32'h805);
            chk("t5_cnt",   32'(out_cnt),   32'd2);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_pop", 32'(out_valid), 32'd0);
        beat(7'h01, 1'b1);
        chk("t5_next_sum", 32'(out_sum), 32'h001);
        chk("t5_next_cnt", 32'(out_cnt), 32'd1);
        @(posedge clk);
        #1;

        // 6: asynchronous reset mid-frame
        beat(7'h02, 1'b0);
        beat(7'h02, 1'b0);
        beat(7'h02, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_sum",   32'(out_sum),   32'd0);
        chk("t6_ovf",   32'(out_ovf),   32'd0);
        chk("t6_cnt",   32'(out_cnt),   32'd0);
        chk("t6_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(7'h47, 1'b0);
        beat(7'h47, 1'b1);
        chk("t6_sum2", 32'(out_sum), 32'h80E);
        chk("t6_cnt2", 32'(out_cnt), 32'd2);
        chk("t6_ovf2", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
